// File: rtl/fpa_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential single-precision adder.
// The master side presents operands and accepts results; the slave is the controller.
interface fpa_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [32:1] a;
    logic [32:1] b;
    logic        out_valid;
    logic        out_ready;
    logic [32:1] result;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fpa_seq_ctrl.sv
// Multi-cycle IEEE-754 single-precision adder: load/order, serial align,
// one shared 25-bit add, serial normalize, then hold the result until accepted.
module fpa_seq_ctrl (
    input  logic          clk,
    input  logic          rst,
    fpa_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [32:1] r_a, r_b, r_result;
    logic [32:1] w_a, w_b, w_result;
    logic [23:0] r_mant_l, r_mant_s, w_mant_l, w_mant_s;
    logic [24:0] r_sum, w_sum;
    logic [7:0]  r_exp, r_d, w_exp, w_d;
    logic        r_sign, r_sub, w_sign, w_sub;

    // Denormals are flushed: a zero exponent also clears the hidden bit and fraction.
    logic [23:0] w_mant_a, w_mant_b;
    logic        w_a_ge_b;
    assign w_mant_a = (r_a[31:24] == 8'd0) ? 24'd0 : {1'b1, r_a[23:1]};
    assign w_mant_b = (r_b[31:24] == 8'd0) ? 24'd0 : {1'b1, r_b[23:1]};
    assign w_a_ge_b = {r_a[31:24], w_mant_a} >= {r_b[31:24], w_mant_b};

    // The single mantissa adder; subtraction is L + ~S + 1 with the carry dropped.
    logic [24:0] w_addend, w_adder_out;
    assign w_addend    = r_sub ? ~{1'b0, r_mant_s} : {1'b0, r_mant_s};
    assign w_adder_out = {1'b0, r_mant_l} + w_addend + {24'd0, r_sub};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_a         = r_a;
        w_b         = r_b;
        w_result    = r_result;
        w_mant_l    = r_mant_l;
        w_mant_s    = r_mant_s;
        w_sum       = r_sum;
        w_exp       = r_exp;
        w_d         = r_d;
        w_sign      = r_sign;
        w_sub       = r_sub;

        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid && !rst) begin
                    w_a         = bus.a;
                    w_b         = bus.b;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_sub = r_a[32] ^ r_b[32];
                if (w_a_ge_b) begin
                    w_mant_l = w_mant_a;
                    w_mant_s = w_mant_b;
                    w_exp    = r_a[31:24];
                    w_sign   = r_a[32];
                    w_d      = r_a[31:24] - r_b[31:24];
                end else begin
                    w_mant_l = w_mant_b;
                    w_mant_s = w_mant_a;
                    w_exp    = r_b[31:24];
                    w_sign   = r_b[32];
                    w_d      = r_b[31:24] - r_a[31:24];
                end
                w_state_nxt = (w_d == 8'd0) ? S_ADD : S_ALIGN;
            end
            S_ALIGN: begin
                if (r_d >= 8'd25) begin
                    w_mant_s    = 24'd0;
                    w_d         = 8'd0;
                    w_state_nxt = S_ADD;
                end else begin
                    w_mant_s = r_mant_s >> 1;
                    w_d      = r_d - 8'd1;
                    if (r_d == 8'd1)
                        w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_sum       = w_adder_out;
                w_state_nxt = S_NORM;
            end
            S_NORM: begin
                if (r_sum == 25'd0) begin
                    w_result    = 32'h0000_0000;
                    w_state_nxt = S_DONE;
                end else if (r_sum[24]) begin
                    if (r_exp >= 8'd254)
                        w_result = {r_sign, 8'hFF, 23'd0};
                    else
                        w_result = {r_sign, r_exp + 8'd1, r_sum[23:1]};
                    w_state_nxt = S_DONE;
                end else if (r_sum[23]) begin
                    if (r_exp == 8'hFF)
                        w_result = {r_sign, 8'hFF, 23'd0};
                    else
                        w_result = {r_sign, r_exp, r_sum[22:0]};
                    w_state_nxt = S_DONE;
                end else if (r_exp <= 8'd1) begin
                    // The pending left shift would take the exponent to zero: flush to +0.
                    w_result    = 32'h0000_0000;
                    w_state_nxt = S_DONE;
                end else begin
                    w_sum = {r_sum[23:0], 1'b0};
                    w_exp = r_exp - 8'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result;
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never reads them before loading them.
    always_ff @(posedge clk) begin
        r_a      <= w_a;
        r_b      <= w_b;
        r_mant_l <= w_mant_l;
        r_mant_s <= w_mant_s;
        r_sum    <= w_sum;
        r_exp    <= w_exp;
        r_d      <= w_d;
        r_sign   <= w_sign;
        r_sub    <= w_sub;
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = r_result;
endmodule

// File: tb/tb_fpa_seq_ctrl.sv
// Directed self-checking bench for fpa_seq_ctrl: scoreboarded sums and latencies,
// result hold under back-pressure, and synchronous reset mid-operation.
module tb_fpa_seq_ctrl;
    logic clk = 1'b0;
    logic rst;

    fpa_seq_ctrl_if bus ();

    fpa_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:1] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Handshake one operand pair, then wait (bounded) for out_valid and score it.
    // A negative expected latency means only the result value is scored.
    task automatic run_op(input logic [32:1] a_v, input logic [32:1] b_v,
                          input logic [32:1] exp_r, input int exp_lat,
                          input string tag, input int hold);
        exp_t e;
        int   lat;
        logic [32:1] held;
        sb_q.push_back('{res: exp_r, lat: exp_lat, tag: tag});
        @(negedge clk);
        bus.a        = a_v;
        bus.b        = b_v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        e = sb_q.pop_front();
        check({e.tag, " valid"}, 32'(bus.out_valid), 32'd1);
        check({e.tag, " result"}, bus.result, e.res);
        if (e.lat >= 0)
            check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.a        = 32'h4000_0000;
            bus.b        = 32'h4000_0000;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check({e.tag, " hold result"}, bus.result, held);
            check({e.tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            check({e.tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            check({e.tag, " hold busy"}, 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({e.tag, " release in_ready"}, 32'(bus.in_ready), 32'd1);
        check({e.tag, " release out_valid"}, 32'(bus.out_valid), 32'd0);
        if (hold > 0) begin
            check({e.tag, " release busy"}, 32'(bus.busy), 32'd0);
            check({e.tag, " release result kept"}, bus.result, held);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset result", bus.result, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, "1+1", 0);
        run_op(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3, "1-1", 0);
        run_op(32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 5, "1.5+0.25", 0);
        run_op(32'h4E80_0000, 32'h3F80_0000, 32'h4E80_0000, 4, "d30", 0);
        run_op(32'h3FC0_0000, 32'hBFA0_0000, 32'h3E80_0000, 5, "1.5-1.25", 0);
        run_op(32'h3F80_0000, 32'hBE80_0000, 32'h3F40_0000, 6, "1-0.25", 0);
        run_op(32'h3E80_0000, 32'hBF80_0000, 32'hBF40_0000, 6, "0.25-1 swap", 0);
        run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3, "overflow inf", 0);
        run_op(32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 4, "denorm flush", 0);
        run_op(32'h00C0_0000, 32'h8080_0000, 32'h0000_0000, -1, "underflow", 0);
        run_op(32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001, 26, "d23", 0);
        run_op(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 27, "d24", 0);
        run_op(32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 4, "d25", 0);
        run_op(32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 5, "hold", 3);

        // Reset while the d=24 alignment is in progress.
        @(negedge clk);
        bus.a        = 32'h4B80_0000;
        bus.b        = 32'h3F80_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid align busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst busy", 32'(bus.busy), 32'd0);
        check("mid rst result", bus.result, 32'h0000_0000);

        // Reset together with in_valid must not start an operation.
        bus.a        = 32'h3F80_0000;
        bus.b        = 32'h3F80_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst+valid busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst+valid no capture", 32'(bus.busy), 32'd0);

        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, "after rst", 0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
